serial_adder: RTL and testbench

- Bit-serial N-bit adder; the addition counterpart of the combinational full-subtractor.
- Latches two operands and a carry-in, then adds LSB-first through a single full-adder cell, one bit per clock.
- Presents a registered sum and carry-out with a one-cycle done pulse.
- Serves as the area-cheap arithmetic engine for multi-cycle datapaths.

---
 rtl/serial_adder_pkg.sv | 25 ++
 rtl/serial_adder_if.sv | 18 +
 rtl/serial_adder_fa_ha.sv | 25 ++
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
//   - state_t       : sequencer state encoding (IDLE/SHIFT/DONE)
//   - DEFAULT_WIDTH : default operand width
//   - cnt_width()   : bit counter width, never below one bit
//   - half_add()    : half-adder cell, returns {carry, sum}
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Counter must hold 0..WIDTH-1; a 1-bit adder still needs a 1-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the bit-serial adder.
//   master: drives start, a, b, cin; observes busy, done, sum, cout.
//   slave : the adder side (opposite directions).
interface serial_adder_if #(
  parameter int WIDTH = serial_adder_pkg::DEFAULT_WIDTH
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/serial_adder_fa_ha.sv
// fa_ha: combinational full adder composed of two half adders.
//   a, b, cin : input bits
//   sum, cout : sum bit and carry out
module fa_ha
  import serial_adder_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic [1:0] w_ha0;
  logic [1:0] w_ha1;

  // First half adder on the operands, second folds in the carry.
  always_comb begin
    w_ha0 = half_add(a, b);
    w_ha1 = half_add(w_ha0[0], cin);
    sum   = w_ha1[0];
    cout  = w_ha0[1] | w_ha1[1];
  end

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : serial_adder_if.slave (start/a/b/cin in, busy/done/sum/cout out)
// sum/cout are updated only at completion; done pulses one cycle, WIDTH
// clocks after the accepted start edge.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_adder_if.slave       bus
);

  localparam int                 CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic             w_bit_sum;
  logic             w_bit_carry;
  logic [WIDTH-1:0] w_res_next;

  fa_ha u_cell (
    .a    (r_a_sr[0]),
    .b    (r_b_sr[0]),
    .cin  (r_carry),
    .sum  (w_bit_sum),
    .cout (w_bit_carry)
  );

  // New sum bit enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
  generate
    if (WIDTH == 1) begin : g_res_w1
      assign w_res_next = w_bit_sum;
    end else begin : g_res_wn
      assign w_res_next = {w_bit_sum, r_res[WIDTH-1:1]};
    end
  endgenerate

  // Sequencer: operand capture, per-bit shift/add, result publish.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_carry <= w_bit_carry;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_LAST) begin
            r_sum   <= w_res_next;
            r_cout  <= w_bit_carry;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder.
// Two instances: WIDTH=8 (main scenarios) and WIDTH=1 (width corner).
module tb_serial_adder;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(8)) if8 ();
  serial_adder_if #(.WIDTH(1)) if1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count done pulses of the 8-bit instance (value before this edge's update).
  always @(posedge clk) begin
    if (if8.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 8-bit operation with cycle-accurate busy/done checks.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic [7:0] exp_sum, input logic exp_cout);
    int d0;
    d0 = done_cnt;
    if8.a = a; if8.b = b; if8.cin = cin; if8.start = 1'b1;
    tick();                           // start edge E0
    if8.start = 1'b0;
    for (int i = 1; i < 8; i++) begin
      check({tag, "_busy"}, {31'd0, if8.busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, if8.done}, 32'd0);
      tick();
    end
    check({tag, "_busy_last"}, {31'd0, if8.busy}, 32'd1);
    tick();                           // edge E8
    check({tag, "_done"}, {31'd0, if8.done}, 32'd1);
    check({tag, "_busy_off"}, {31'd0, if8.busy}, 32'd0);
    check({tag, "_sum"}, {24'd0, if8.sum}, {24'd0, exp_sum});
    check({tag, "_cout"}, {31'd0, if8.cout}, {31'd0, exp_cout});
    tick();
    check({tag, "_done_off"}, {31'd0, if8.done}, 32'd0);
    check({tag, "_sum_hold"}, {24'd0, if8.sum}, {24'd0, exp_sum});
    check({tag, "_one_pulse"}, 32'(done_cnt - d0), 32'd1);
  endtask

  initial begin
    int d0;
    rst_n = 1'b0;
    if8.start = 1'b1; if8.a = 8'hFF; if8.b = 8'hFF; if8.cin = 1'b1;
    if1.start = 1'b1; if1.a = 1'b1;  if1.b = 1'b1;  if1.cin = 1'b1;

    // Reset with start held high: nothing may start.
    tick();
    tick();
    check("rst_busy", {31'd0, if8.busy}, 32'd0);
    check("rst_done", {31'd0, if8.done}, 32'd0);
    check("rst_sum",  {24'd0, if8.sum},  32'd0);
    check("rst_cout", {31'd0, if8.cout}, 32'd0);
    check("rst1_busy", {31'd0, if1.busy}, 32'd0);
    check("rst1_sum",  {31'd0, if1.sum},  32'd0);
    if8.start = 1'b0; if1.start = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle_busy", {31'd0, if8.busy}, 32'd0);

    // Main function and wrap cases.
    run_op("basic",  8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
    run_op("wrap1",  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run_op("wrap2",  8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
    run_op("msb",    8'h80, 8'h80, 1'b0, 8'h00, 1'b1);
    run_op("alt",    8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // Isolation: change a and re-pulse start mid-operation.
    d0 = done_cnt;
    if8.a = 8'h10; if8.b = 8'h20; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    if8.a = 8'hAA; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    for (int i = 0; i < 5; i++) tick();   // now just after E8
    check("iso_done", {31'd0, if8.done}, 32'd1);
    check("iso_sum",  {24'd0, if8.sum},  32'h30);
    check("iso_cout", {31'd0, if8.cout}, 32'd0);
    for (int i = 0; i < 12; i++) tick();
    check("iso_pulses", 32'(done_cnt - d0), 32'd1);
    check("iso_idle", {31'd0, if8.busy}, 32'd0);
    check("iso_sum_hold", {24'd0, if8.sum}, 32'h30);

    // Abort by reset mid-operation.
    d0 = done_cnt;
    if8.a = 8'h0F; if8.b = 8'h0F; if8.cin = 1'b0; if8.start = 1'b1;
    tick();
    if8.start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", {31'd0, if8.busy}, 32'd0);
    check("abort_done", {31'd0, if8.done}, 32'd0);
    check("abort_sum",  {24'd0, if8.sum},  32'd0);
    check("abort_cout", {31'd0, if8.cout}, 32'd0);
    for (int i = 0; i < 10; i++) tick();
    check("abort_nodone", 32'(done_cnt - d0), 32'd0);
    run_op("post_abort", 8'h01, 8'h02, 1'b1, 8'h04, 1'b0);

    // Width corner: 1-bit adder finishes one clock after start.
    if1.a = 1'b1; if1.b = 1'b1; if1.cin = 1'b1; if1.start = 1'b1;
    tick();
    if1.start = 1'b0;
    check("w1_busy", {31'd0, if1.busy}, 32'd1);
    check("w1_nodone", {31'd0, if1.done}, 32'd0);
    tick();
    check("w1_done", {31'd0, if1.done}, 32'd1);
    check("w1_sum",  {31'd0, if1.sum},  32'd1);
    check("w1_cout", {31'd0, if1.cout}, 32'd1);
    tick();
    check("w1_done_off", {31'd0, if1.done}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
